// File: rtl/mips_mc_sequencer_if.sv
// Control bundle between the multi-cycle sequencer and the MIPS datapath.
// The sequencer (master) receives the IR opcode field and the memory ready
// handshake, and drives every datapath enable and mux select.
interface mips_mc_sequencer_if;
  logic [5:0] opcode;
  logic       mem_ready;

  logic       pc_write;
  logic       pc_write_cond;
  logic       branch_ne;
  logic [1:0] pc_source;
  logic       i_or_d;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       reg_dst;
  logic       memto_reg;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [2:0] imm_op;
  logic       sign_or_zero;
  logic [3:0] state;
  logic       instr_done;
  logic       illegal;
  logic       mem_timeout;

  modport master (
    input  opcode, mem_ready,
    output pc_write, pc_write_cond, branch_ne, pc_source, i_or_d,
           mem_read, mem_write, ir_write, reg_dst, memto_reg, reg_write,
           alu_src_a, alu_src_b, alu_op, imm_op, sign_or_zero, state,
           instr_done, illegal, mem_timeout
  );

  modport slave (
    output opcode, mem_ready,
    input  pc_write, pc_write_cond, branch_ne, pc_source, i_or_d,
           mem_read, mem_write, ir_write, reg_dst, memto_reg, reg_write,
           alu_src_a, alu_src_b, alu_op, imm_op, sign_or_zero, state,
           instr_done, illegal, mem_timeout
  );
endinterface

// File: rtl/mips_mc_sequencer.sv
// Multi-cycle Moore control sequencer for the non-pipelined MIPS core.
// Steps each instruction through fetch/decode/execute/memory/writeback and
// stalls in FETCH, MEM_RD and MEM_WR on the memory ready handshake, aborting
// back to FETCH if the memory does not answer within WAIT_LIMIT cycles.
module mips_mc_sequencer #(
  parameter int WAIT_LIMIT = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  mips_mc_sequencer_if.master  bus
);

  localparam int CW = (WAIT_LIMIT < 1) ? 1 : $clog2(WAIT_LIMIT + 1);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_EXEC_R   = 4'd6,
    S_R_WB     = 4'd7,
    S_EXEC_I   = 4'd8,
    S_I_WB     = 4'd9,
    S_BRANCH   = 4'd10,
    S_JUMP     = 4'd11
  } state_t;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       branch_ne;
    logic [1:0] pc_source;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       memto_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [2:0] imm_op;
    logic       sign_or_zero;
    logic       instr_done;
    logic       illegal;
    logic       mem_timeout;
  } ctl_t;

  state_t        state_q, state_d;
  logic [5:0]    op_q;
  logic [CW-1:0] wait_cnt;
  logic          wait_expired;
  logic [2:0]    imm_op_dec;
  logic          imm_sign_dec;
  ctl_t          ctl, ctl_out;

  assign wait_expired = (wait_cnt == CW'(WAIT_LIMIT));

  // Immediate ALU operation and extension mode, from the opcode latched in DECODE.
  always_comb begin
    imm_op_dec   = 3'b000;
    imm_sign_dec = 1'b0;
    case (op_q)
      OP_ADDI: begin imm_op_dec = 3'b000; imm_sign_dec = 1'b1; end
      OP_ANDI: begin imm_op_dec = 3'b001; imm_sign_dec = 1'b0; end
      OP_ORI:  begin imm_op_dec = 3'b010; imm_sign_dec = 1'b0; end
      OP_SLTI: begin imm_op_dec = 3'b011; imm_sign_dec = 1'b1; end
      default: begin imm_op_dec = 3'b000; imm_sign_dec = 1'b0; end
    endcase
  end

  // Next-state and Moore output decode; mem_ready only gates the wait states.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path
    // through the case can leave one unassigned and infer a latch.
    state_d = state_q;
    ctl     = '0;
    case (state_q)
      S_FETCH: begin
        ctl.mem_read  = 1'b1;
        ctl.alu_src_b = 2'b01;
        if (wait_expired) begin
          ctl.mem_timeout = 1'b1;
          state_d         = S_FETCH;
        end else if (bus.mem_ready) begin
          ctl.ir_write = 1'b1;
          ctl.pc_write = 1'b1;
          state_d      = S_DECODE;
        end
      end
      S_DECODE: begin
        ctl.alu_src_b = 2'b11;
        case (bus.opcode)
          OP_LW, OP_SW:                      state_d = S_MEM_ADDR;
          OP_RTYPE:                          state_d = S_EXEC_R;
          OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: state_d = S_EXEC_I;
          OP_BEQ, OP_BNE:                    state_d = S_BRANCH;
          OP_J:                              state_d = S_JUMP;
          default: begin
            ctl.illegal = 1'b1;
            state_d     = S_FETCH;
          end
        endcase
      end
      S_MEM_ADDR: begin
        ctl.alu_src_a    = 1'b1;
        ctl.alu_src_b    = 2'b10;
        ctl.sign_or_zero = 1'b1;
        state_d          = (op_q == OP_SW) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        ctl.mem_read = 1'b1;
        ctl.i_or_d   = 1'b1;
        if (wait_expired) begin
          ctl.mem_timeout = 1'b1;
          state_d         = S_FETCH;
        end else if (bus.mem_ready) begin
          state_d = S_MEM_WB;
        end
      end
      S_MEM_WB: begin
        ctl.reg_write  = 1'b1;
        ctl.memto_reg  = 1'b1;
        ctl.instr_done = 1'b1;
        state_d        = S_FETCH;
      end
      S_MEM_WR: begin
        ctl.mem_write = 1'b1;
        ctl.i_or_d    = 1'b1;
        if (wait_expired) begin
          ctl.mem_timeout = 1'b1;
          state_d         = S_FETCH;
        end else if (bus.mem_ready) begin
          ctl.instr_done = 1'b1;
          state_d        = S_FETCH;
        end
      end
      S_EXEC_R: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_op    = 2'b10;
        state_d       = S_R_WB;
      end
      S_R_WB: begin
        ctl.reg_write  = 1'b1;
        ctl.reg_dst    = 1'b1;
        ctl.instr_done = 1'b1;
        state_d        = S_FETCH;
      end
      S_EXEC_I: begin
        ctl.alu_src_a    = 1'b1;
        ctl.alu_src_b    = 2'b10;
        ctl.alu_op       = 2'b11;
        ctl.imm_op       = imm_op_dec;
        ctl.sign_or_zero = imm_sign_dec;
        state_d          = S_I_WB;
      end
      S_I_WB: begin
        ctl.reg_write    = 1'b1;
        ctl.instr_done   = 1'b1;
        ctl.imm_op       = imm_op_dec;
        ctl.sign_or_zero = imm_sign_dec;
        state_d          = S_FETCH;
      end
      S_BRANCH: begin
        ctl.alu_src_a     = 1'b1;
        ctl.alu_op        = 2'b01;
        ctl.pc_source     = 2'b01;
        ctl.pc_write_cond = 1'b1;
        ctl.branch_ne     = (op_q == OP_BNE);
        ctl.instr_done    = 1'b1;
        state_d           = S_FETCH;
      end
      S_JUMP: begin
        ctl.pc_write   = 1'b1;
        ctl.pc_source  = 2'b10;
        ctl.instr_done = 1'b1;
        state_d        = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // State, latched opcode and handshake wait counter.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!reset) begin
      state_q  <= S_FETCH;
      op_q     <= '0;
      wait_cnt <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) begin
        op_q <= bus.opcode;
      end
      // Non-wait states never loop on themselves, so any state change (or an
      // abort back into FETCH) is the point where a fresh wait begins.
      if ((state_d != state_q) || ctl.mem_timeout) begin
        wait_cnt <= '0;
      end else if (!bus.mem_ready && !wait_expired) begin
        wait_cnt <= wait_cnt + CW'(1);
      end
    end
  end

  // Reset holds every control low combinationally, so a reset landing in a
  // wait state can never leak a write enable.
  assign ctl_out = reset ? ctl : '0;

  assign bus.pc_write      = ctl_out.pc_write;
  assign bus.pc_write_cond = ctl_out.pc_write_cond;
  assign bus.branch_ne     = ctl_out.branch_ne;
  assign bus.pc_source     = ctl_out.pc_source;
  assign bus.i_or_d        = ctl_out.i_or_d;
  assign bus.mem_read      = ctl_out.mem_read;
  assign bus.mem_write     = ctl_out.mem_write;
  assign bus.ir_write      = ctl_out.ir_write;
  assign bus.reg_dst       = ctl_out.reg_dst;
  assign bus.memto_reg     = ctl_out.memto_reg;
  assign bus.reg_write     = ctl_out.reg_write;
  assign bus.alu_src_a     = ctl_out.alu_src_a;
  assign bus.alu_src_b     = ctl_out.alu_src_b;
  assign bus.alu_op        = ctl_out.alu_op;
  assign bus.imm_op        = ctl_out.imm_op;
  assign bus.sign_or_zero  = ctl_out.sign_or_zero;
  assign bus.instr_done    = ctl_out.instr_done;
  assign bus.illegal       = ctl_out.illegal;
  assign bus.mem_timeout   = ctl_out.mem_timeout;
  assign bus.state         = reset ? state_q : S_FETCH;

endmodule

// File: tb/tb_mips_mc_sequencer.sv
// Directed bench for mips_mc_sequencer: reset, instruction timing, control
// decode per state, memory waits, illegal opcodes and handshake timeout.
module tb_mips_mc_sequencer;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_BAD   = 6'b111111;

  // Enable-vector bit values, see en below.
  localparam logic [12:0] E_PC_WRITE  = 13'h1000;
  localparam logic [12:0] E_PC_COND   = 13'h0800;
  localparam logic [12:0] E_BRANCH_NE = 13'h0400;
  localparam logic [12:0] E_I_OR_D    = 13'h0200;
  localparam logic [12:0] E_MEM_READ  = 13'h0100;
  localparam logic [12:0] E_MEM_WRITE = 13'h0080;
  localparam logic [12:0] E_IR_WRITE  = 13'h0040;
  localparam logic [12:0] E_REG_WRITE = 13'h0020;
  localparam logic [12:0] E_REG_DST   = 13'h0010;
  localparam logic [12:0] E_MEMTO_REG = 13'h0008;
  localparam logic [12:0] E_DONE      = 13'h0004;
  localparam logic [12:0] E_ILLEGAL   = 13'h0002;

  logic clk = 1'b0;
  logic reset;
  int   compares   = 0;
  int   mismatches = 0;

  always #5 clk = ~clk;

  mips_mc_sequencer_if bus ();
  mips_mc_sequencer_if bus_t ();

  mips_mc_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  mips_mc_sequencer #(.WAIT_LIMIT(4)) dut_t (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_t)
  );

  logic [12:0] en;
  logic [23:0] all_out;
  assign en = {bus.pc_write, bus.pc_write_cond, bus.branch_ne, bus.i_or_d,
               bus.mem_read, bus.mem_write, bus.ir_write, bus.reg_write,
               bus.reg_dst, bus.memto_reg, bus.instr_done, bus.illegal,
               bus.mem_timeout};
  assign all_out = {en, bus.pc_source, bus.alu_src_a, bus.alu_src_b,
                    bus.alu_op, bus.imm_op, bus.sign_or_zero};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.mem_ready = 1'b0;   bus.opcode = OP_RTYPE;
    bus_t.mem_ready = 1'b0; bus_t.opcode = OP_RTYPE;
    for (int i = 0; i < 3; i++) begin
      tick();
      #1;
      compares++;
      if (all_out !== 24'h0) begin
        $display("FAIL reset_outputs cycle %0d: got %h want 000000", i, all_out);
        mismatches++;
      end
      compares++;
      if (bus.state !== 4'd0) begin
        $display("FAIL reset_state cycle %0d: got %0d want 0", i, bus.state);
        mismatches++;
      end
    end
    reset = 1'b1;
    tick();
    #1;
    compares++;
    if ({bus.state, en, bus.alu_src_b} !== {4'd0, E_MEM_READ, 2'b01}) begin
      $display("FAIL first_fetch: got state=%0d en=%h srcb=%b want state=0 en=%h srcb=01",
               bus.state, en, bus.alu_src_b, E_MEM_READ);
      mismatches++;
    end
  endtask

  // lw, sw, add, beq, j back to back with mem_ready held high.
  task automatic test_back_to_back();
    logic [3:0] exp_st [19] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4,
                                4'd0, 4'd1, 4'd2, 4'd5,
                                4'd0, 4'd1, 4'd6, 4'd7,
                                4'd0, 4'd1, 4'd10,
                                4'd0, 4'd1, 4'd11};
    logic exp_done, exp_rw;
    bus.mem_ready = 1'b1;
    for (int c = 1; c <= 19; c++) begin
      bus.opcode = (c <= 5) ? OP_LW : (c <= 9) ? OP_SW : (c <= 13) ? OP_RTYPE :
                   (c <= 16) ? OP_BEQ : OP_J;
      #1;
      exp_done = (c == 5) || (c == 9) || (c == 13) || (c == 16) || (c == 19);
      exp_rw   = (c == 5) || (c == 13);
      compares++;
      if ({bus.state, bus.instr_done, bus.reg_write} !== {exp_st[c-1], exp_done, exp_rw}) begin
        $display("FAIL b2b cycle %0d: got state=%0d done=%b rw=%b want state=%0d done=%b rw=%b",
                 c, bus.state, bus.instr_done, bus.reg_write, exp_st[c-1], exp_done, exp_rw);
        mismatches++;
      end
      tick();
    end
  endtask

  task automatic test_ori_bne();
    bus.mem_ready = 1'b1;
    bus.opcode = OP_ORI;
    #1;
    compares++;
    if (en !== (E_MEM_READ | E_IR_WRITE | E_PC_WRITE)) begin
      $display("FAIL ori_fetch: got en=%h want %h", en, E_MEM_READ | E_IR_WRITE | E_PC_WRITE);
      mismatches++;
    end
    tick();
    #1;
    compares++;
    if ({bus.state, bus.alu_src_a, bus.alu_src_b, bus.alu_op} !== {4'd1, 1'b0, 2'b11, 2'b00}) begin
      $display("FAIL ori_decode: got state=%0d a=%b b=%b op=%b want 1/0/11/00",
               bus.state, bus.alu_src_a, bus.alu_src_b, bus.alu_op);
      mismatches++;
    end
    tick();
    bus.opcode = OP_RTYPE;  // ignored outside DECODE
    #1;
    compares++;
    if ({bus.state, bus.alu_src_a, bus.alu_src_b, bus.alu_op, bus.imm_op, bus.sign_or_zero, en}
        !== {4'd8, 1'b1, 2'b10, 2'b11, 3'b010, 1'b0, 13'h0}) begin
      $display("FAIL ori_exec_i: got state=%0d b=%b op=%b imm=%b sz=%b en=%h want 8/10/11/010/0/0000",
               bus.state, bus.alu_src_b, bus.alu_op, bus.imm_op, bus.sign_or_zero, en);
      mismatches++;
    end
    tick();
    #1;
    compares++;
    if ({bus.state, bus.imm_op, bus.sign_or_zero, en} !== {4'd9, 3'b010, 1'b0, E_REG_WRITE | E_DONE}) begin
      $display("FAIL ori_i_wb: got state=%0d imm=%b sz=%b en=%h want 9/010/0/%h",
               bus.state, bus.imm_op, bus.sign_or_zero, en, E_REG_WRITE | E_DONE);
      mismatches++;
    end
    tick();
    bus.opcode = OP_BNE;
    tick();
    tick();
    bus.opcode = OP_BEQ;    // latched bne must stand
    #1;
    compares++;
    if ({bus.state, bus.pc_source, bus.alu_src_a, bus.alu_src_b, bus.alu_op, en}
        !== {4'd10, 2'b01, 1'b1, 2'b00, 2'b01, E_PC_COND | E_BRANCH_NE | E_DONE}) begin
      $display("FAIL bne_branch: got state=%0d src=%b op=%b en=%h want 10/01/01/%h",
               bus.state, bus.pc_source, bus.alu_op, en, E_PC_COND | E_BRANCH_NE | E_DONE);
      mismatches++;
    end
    tick();
    #1;
    compares++;
    if (bus.state !== 4'd0) begin
      $display("FAIL bne_return: got state=%0d want 0", bus.state);
      mismatches++;
    end
  endtask

  // lw with mem_ready low for the first two MEM_RD cycles: 7 cycles total.
  task automatic test_lw_wait();
    int n = 0;
    bus.opcode = OP_LW;
    while (n < 20) begin
      n++;
      bus.mem_ready = !(n == 4 || n == 5);
      #1;
      if (n >= 4 && n <= 6) begin
        compares++;
        if ({bus.state, en} !== {4'd3, E_MEM_READ | E_I_OR_D}) begin
          $display("FAIL lw_wait cycle %0d: got state=%0d en=%h want 3/%h",
                   n, bus.state, en, E_MEM_READ | E_I_OR_D);
          mismatches++;
        end
      end
      if (bus.instr_done) break;
      tick();
    end
    compares++;
    if ({n, bus.state, en} !== {32'd7, 4'd4, E_REG_WRITE | E_MEMTO_REG | E_DONE}) begin
      $display("FAIL lw_wait_done: got cycles=%0d state=%0d en=%h want 7/4/%h",
               n, bus.state, en, E_REG_WRITE | E_MEMTO_REG | E_DONE);
      mismatches++;
    end
    tick();
  endtask

  // sw with one wait cycle in MEM_WR; done only in the mem_ready cycle.
  task automatic test_sw_wait();
    int n = 0;
    bus.opcode = OP_SW;
    while (n < 20) begin
      n++;
      bus.mem_ready = (n != 4);
      #1;
      if (n == 4) begin
        compares++;
        if ({bus.state, en} !== {4'd5, E_MEM_WRITE | E_I_OR_D}) begin
          $display("FAIL sw_wait: got state=%0d en=%h want 5/%h", bus.state, en, E_MEM_WRITE | E_I_OR_D);
          mismatches++;
        end
      end
      if (bus.instr_done) break;
      tick();
    end
    compares++;
    if ({n, bus.state, en} !== {32'd5, 4'd5, E_MEM_WRITE | E_I_OR_D | E_DONE}) begin
      $display("FAIL sw_wait_done: got cycles=%0d state=%0d en=%h want 5/5/%h",
               n, bus.state, en, E_MEM_WRITE | E_I_OR_D | E_DONE);
      mismatches++;
    end
    tick();
  endtask

  task automatic test_illegal();
    bus.mem_ready = 1'b1;
    bus.opcode = OP_BAD;
    tick();
    #1;
    compares++;
    if ({bus.state, en} !== {4'd1, E_ILLEGAL}) begin
      $display("FAIL illegal_decode: got state=%0d en=%h want 1/%h", bus.state, en, E_ILLEGAL);
      mismatches++;
    end
    tick();
    bus.mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      compares++;
      if ({bus.state, bus.reg_write, bus.mem_write, bus.pc_write, bus.illegal} !== {4'd0, 4'b0000}) begin
        $display("FAIL illegal_after cycle %0d: got state=%0d rw=%b mw=%b pw=%b il=%b want 0/0/0/0/0",
                 i, bus.state, bus.reg_write, bus.mem_write, bus.pc_write, bus.illegal);
        mismatches++;
      end
      tick();
    end
  endtask

  // Reset asserted while a store waits in MEM_WR: no write enable escapes.
  task automatic test_reset_abort();
    bus.mem_ready = 1'b1;
    bus.opcode = OP_SW;
    tick();
    tick();
    bus.mem_ready = 1'b0;
    tick();
    #1;
    compares++;
    if ({bus.state, bus.mem_write} !== {4'd5, 1'b1}) begin
      $display("FAIL abort_setup: got state=%0d mw=%b want 5/1", bus.state, bus.mem_write);
      mismatches++;
    end
    reset = 1'b0;
    bus.mem_ready = 1'b1;
    #1;
    compares++;
    if ({bus.state, all_out} !== {4'd0, 24'h0}) begin
      $display("FAIL abort_in_reset: got state=%0d outs=%h want 0/000000", bus.state, all_out);
      mismatches++;
    end
    tick();
    tick();
    bus.mem_ready = 1'b0;
    bus_t.mem_ready = 1'b0;
    reset = 1'b1;
    tick();
    #1;
    compares++;
    if ({bus.state, en} !== {4'd0, E_MEM_READ}) begin
      $display("FAIL abort_restart: got state=%0d en=%h want 0/%h", bus.state, en, E_MEM_READ);
      mismatches++;
    end
  endtask

  // WAIT_LIMIT=4 instance: FETCH with no mem_ready aborts every 5th cycle.
  task automatic test_timeout();
    logic exp_to;
    bus_t.mem_ready = 1'b1;
    bus_t.opcode = OP_J;
    #1;
    compares++;
    if ({bus_t.state, bus_t.ir_write} !== {4'd0, 1'b1}) begin
      $display("FAIL to_fetch: got state=%0d irw=%b want 0/1", bus_t.state, bus_t.ir_write);
      mismatches++;
    end
    tick();
    tick();
    bus_t.mem_ready = 1'b0;
    tick();
    for (int c = 1; c <= 10; c++) begin
      #1;
      exp_to = (c == 5) || (c == 10);
      compares++;
      if ({bus_t.state, bus_t.mem_timeout, bus_t.ir_write, bus_t.pc_write, bus_t.mem_read}
          !== {4'd0, exp_to, 1'b0, 1'b0, 1'b1}) begin
        $display("FAIL timeout cycle %0d: got state=%0d to=%b irw=%b pw=%b mr=%b want 0/%b/0/0/1",
                 c, bus_t.state, bus_t.mem_timeout, bus_t.ir_write, bus_t.pc_write,
                 bus_t.mem_read, exp_to);
        mismatches++;
      end
      tick();
    end
    bus_t.mem_ready = 1'b1;
    #1;
    compares++;
    if ({bus_t.ir_write, bus_t.pc_write, bus_t.mem_timeout} !== 3'b110) begin
      $display("FAIL timeout_refetch: got irw=%b pw=%b to=%b want 1/1/0",
               bus_t.ir_write, bus_t.pc_write, bus_t.mem_timeout);
      mismatches++;
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_ori_bne();
    test_lw_wait();
    test_sw_wait();
    test_illegal();
    test_reset_abort();
    test_timeout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, mismatches);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no end of run by 100000 ns, want completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mips_mc_sequencer.md
# mips_mc_sequencer

Multi-cycle control sequencer for the non-pipelined MIPS core. It replaces the single-cycle opcode decoder with a Moore state machine. The machine steps each instruction through fetch, decode, execute, memory and writeback, and drives the shared ALU, memory port, register file and PC enables one phase at a time. It sits between the instruction register opcode field and the datapath muxes, and stalls on a memory ready handshake.

## Interface
Parameters:
- `WAIT_LIMIT`, default 255: maximum number of cycles a memory state waits for `mem_ready` before it aborts.

Ports:
- `clk` input 1: the only clock; all state changes on the rising edge.
- `reset` input 1: synchronous reset, active-low. It is sampled on the rising edge of `clk`. 0 = reset.
- `opcode` input 6: `instruction[31:26]` from the IR. It is sampled only in DECODE.
- `mem_ready` input 1: the memory has completed the current read or write this cycle.
- `pc_write`, `pc_write_cond`, `branch_ne` output 1 each: PC update controls.
- `pc_source` output 2: PC mux select. 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `i_or_d` output 1: memory address select. 0 = PC, 1 = ALUOut.
- `mem_read`, `mem_write`, `ir_write` output 1 each: memory port and IR enables.
- `reg_dst`, `memto_reg`, `reg_write` output 1 each: register file controls.
- `alu_src_a` output 1: 0 = PC, 1 = rs.
- `alu_src_b` output 2: 00 = rt, 01 = constant 4, 10 = extended immediate, 11 = immediate<<2.
- `alu_op` output 2: 00 = add, 01 = sub, 10 = funct field, 11 = the immediate op held in `imm_op`.
- `imm_op` output 3: for I-type ALU. 000 = add, 001 = and, 010 = or, 011 = slt.
- `sign_or_zero` output 1: 1 = sign-extend the immediate, 0 = zero-extend.
- `state` output 4: current state encoding, for debug.
- `instr_done` output 1: one-cycle pulse in the final cycle of each instruction.
- `illegal` output 1: one-cycle pulse on an unsupported opcode.
- `mem_timeout` output 1: one-cycle pulse on a handshake abort.

## Operation
- States and encodings: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_RD=3, MEM_WB=4, MEM_WR=5, EXEC_R=6, R_WB=7, EXEC_I=8, I_WB=9, BRANCH=10, JUMP=11.
- Supported opcodes:
  - R-type 000000
  - lw 100011, sw 101011
  - beq 000100, bne 000101
  - j 000010
  - addi 001000, andi 001100, ori 001101, slti 001010
- FETCH:
  - Drives `mem_read`=1, `i_or_d`=0, `alu_src_a`=0, `alu_src_b`=01, `alu_op`=00, `pc_source`=00.
  - Holds until `mem_ready`=1. In that cycle it also drives `ir_write`=1 and `pc_write`=1, then goes to DECODE.
- DECODE:
  - Drives `alu_src_a`=0, `alu_src_b`=11, `alu_op`=00 to compute the branch target.
  - Latches `opcode` into an internal register.
  - Next state by opcode: lw/sw → MEM_ADDR; R-type → EXEC_R; addi/andi/ori/slti → EXEC_I; beq/bne → BRANCH; j → JUMP.
  - Any other opcode pulses `illegal` and goes to FETCH, with no writes.
- MEM_ADDR: `alu_src_a`=1, `alu_src_b`=10, `alu_op`=00, `sign_or_zero`=1. Next is MEM_RD for lw, MEM_WR for sw.
- MEM_RD: `mem_read`=1, `i_or_d`=1. Holds until `mem_ready`, then goes to MEM_WB.
- MEM_WB: `reg_write`=1, `memto_reg`=1, `reg_dst`=0, `instr_done`=1, then FETCH.
- MEM_WR: `mem_write`=1, `i_or_d`=1. Holds until `mem_ready`. In the `mem_ready` cycle it drives `instr_done`=1, then goes to FETCH.
- EXEC_R: `alu_src_a`=1, `alu_src_b`=00, `alu_op`=10, then R_WB.
- R_WB: `reg_write`=1, `reg_dst`=1, `memto_reg`=0, `instr_done`=1, then FETCH.
- EXEC_I: `alu_src_a`=1, `alu_src_b`=10, `alu_op`=11.
  - `imm_op`: addi 000, andi 001, ori 010, slti 011.
  - `sign_or_zero`: 0 for andi/ori, 1 for addi/slti.
  - Next state is I_WB.
- I_WB:
  - `reg_write`=1, `reg_dst`=0, `memto_reg`=0, `instr_done`=1, then FETCH.
  - `imm_op` and `sign_or_zero` hold their EXEC_I values.
- BRANCH:
  - `alu_src_a`=1, `alu_src_b`=00, `alu_op`=01, `pc_source`=01, `pc_write_cond`=1.
  - `branch_ne`=1 for bne, 0 for beq.
  - `instr_done`=1, then FETCH.
- JUMP: `pc_write`=1, `pc_source`=10, `instr_done`=1, then FETCH.
- Every output not listed for a state is 0.
- Handshake timeout:
  - A wait counter clears on entry to FETCH, MEM_RD and MEM_WR, and increments each cycle `mem_ready`=0.
  - If the counter reaches `WAIT_LIMIT` without `mem_ready`, the machine pulses `mem_timeout` and goes to FETCH.
  - The abort issues no `ir_write`, `pc_write` or `reg_write`.

## Timing
- Outputs are a pure decode of registered state plus `mem_ready` (for `ir_write`, `pc_write` and `instr_done` in the wait states). There is no output register.
- Reset:
  - Forces FETCH, clears the wait counter and the latched opcode.
  - Every output is 0 while `reset`=0, except `state`=0.
  - Reset in any state, including a memory wait, aborts the instruction with no write-enable pulse.
  - The first fetch request appears in the first cycle after `reset` is sampled 1.
- Cycles per instruction with `mem_ready` held high:

  | Instruction | Cycles |
  |---|---|
  | lw | 5 |
  | sw | 4 |
  | R-type | 4 |
  | I-type ALU | 4 |
  | beq/bne | 3 |
  | j | 3 |

  Each memory-wait cycle adds 1.
- A `mem_ready` pulse outside FETCH, MEM_RD and MEM_WR is ignored.
- `opcode` changes outside DECODE have no effect.

## Test plan
- Reset held low for 3 cycles, then released: `state`=0 and `mem_read`=1 on the first cycle after release. All other outputs are 0 during reset.
- `mem_ready`=1 constantly, opcodes lw, sw, add, beq, j in turn: `instr_done` pulses at cycles 5, 9, 13, 16, 19. `reg_write` is seen only in MEM_WB (cycle 5) and R_WB (cycle 13).
- ori (001101) then bne (000101):
  - EXEC_I shows `alu_op`=11, `imm_op`=010, `sign_or_zero`=0.
  - BRANCH shows `pc_write_cond`=1, `branch_ne`=1, `pc_source`=01.
- lw with `mem_ready` low for 2 cycles in MEM_RD: `mem_read`=1, `i_or_d`=1 held for 3 cycles. MEM_WB follows, and the lw takes 7 cycles total.
- Opcode 111111: `illegal` pulses in DECODE, the next state is FETCH, and no `reg_write`, `mem_write` or `pc_write` occurs after the fetch.
- `WAIT_LIMIT`=4, `mem_ready` held 0 in FETCH: `mem_timeout` pulses once after 4 wait cycles, with `ir_write`=0 and `pc_write`=0, and the machine restarts FETCH.
